// File: rtl/serial_modulo_detector.sv
// serial_modulo_detector: tracks a serial frame's value modulo DIVISOR, MSB- or LSB-first.
// Define SERIAL_MOD_MATCH_CNT_EN to add the match_count output.
module serial_modulo_detector #(
  parameter int DIVISOR = 3,
  parameter int RW = $clog2(DIVISOR),
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in,
  input  logic             frame_start,
  input  logic             lsb_first,
  output logic             out,
  output logic             out_valid,
  output logic [RW-1:0]    residue,
  output logic [CNT_W-1:0] bit_count
`ifdef SERIAL_MOD_MATCH_CNT_EN
  ,
  output logic [CNT_W-1:0] match_count
`endif
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [RW:0] DV = (RW+1)'(DIVISOR);
  state_t state;
  logic order, lsb;
  logic [RW-1:0] w, base_r, base_w, nr, nw;
  logic [RW:0] sum, dbl;
  logic [CNT_W-1:0] base_cnt, ncnt;
  // frame_start substitutes a fresh frame as the base so a same-cycle bit is its first bit
  always_comb begin
    base_r = frame_start ? '0 : residue;
    base_w = frame_start ? RW'(1) : w;
    lsb = frame_start ? lsb_first : order;
    base_cnt = frame_start ? '0 : bit_count;
    sum = lsb ? {1'b0, base_r} + (in ? {1'b0, base_w} : '0) : {base_r, in};
    dbl = {base_w, 1'b0};
    nr = RW'(sum >= DV ? sum - DV : sum);
    nw = RW'(dbl >= DV ? dbl - DV : dbl);
    ncnt = &base_cnt ? base_cnt : base_cnt + CNT_W'(1);
  end
  assign out_valid = state == RUN;
`ifdef SERIAL_MOD_MATCH_CNT_EN
  logic [CNT_W-1:0] base_m;
  always_comb base_m = frame_start ? '0 : match_count;
  always_ff @(posedge clk or posedge rst)
    if (rst) match_count <= '0;
    else if (in_valid) match_count <= (nr == '0 && !(&base_m)) ? base_m + CNT_W'(1) : base_m;
    else if (frame_start) match_count <= '0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      residue <= '0;
      w <= RW'(1);
      bit_count <= '0;
      out <= 1'b1;
      state <= IDLE;
      order <= 1'b0;
    end else begin
      if (frame_start) order <= lsb_first;
      if (in_valid) begin
        residue <= nr;
        w <= lsb ? nw : base_w;
        bit_count <= ncnt;
        out <= nr == '0;
        state <= RUN;
      end else if (frame_start) begin
        residue <= '0;
        w <= RW'(1);
        bit_count <= '0;
        out <= 1'b1;
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_serial_modulo_detector.sv
// tb_serial_modulo_detector: scoreboard bench over DIVISOR=3, DIVISOR=5 and CNT_W=3 instances.
module tb_serial_modulo_detector;
  logic clk = 0, rst = 1, in_valid = 0, in_bit = 0, frame_start = 0, lsb_first = 0;
  logic d3_out, d3_ov, d5_out, d5_ov, c3_out, c3_ov;
  logic [1:0] d3_res, c3_res;
  logic [2:0] d5_res, c3_cnt;
  logic [7:0] d3_cnt, d5_cnt;
`ifdef SERIAL_MOD_MATCH_CNT_EN
  logic [7:0] d3_mc, d5_mc;
  logic [2:0] c3_mc;
`endif
  int tests = 0, fails = 0;
  typedef struct {int r; int c; bit o; bit v;} exp_t;
  exp_t q[$];
  exp_t e;

  always #5 clk = ~clk;

  serial_modulo_detector #(.DIVISOR(3)) d3 (.clk(clk), .rst(rst), .in_valid(in_valid), .in(in_bit),
    .frame_start(frame_start), .lsb_first(lsb_first), .out(d3_out), .out_valid(d3_ov),
    .residue(d3_res), .bit_count(d3_cnt)
`ifdef SERIAL_MOD_MATCH_CNT_EN
    , .match_count(d3_mc)
`endif
  );
  serial_modulo_detector #(.DIVISOR(5)) d5 (.clk(clk), .rst(rst), .in_valid(in_valid), .in(in_bit),
    .frame_start(frame_start), .lsb_first(lsb_first), .out(d5_out), .out_valid(d5_ov),
    .residue(d5_res), .bit_count(d5_cnt)
`ifdef SERIAL_MOD_MATCH_CNT_EN
    , .match_count(d5_mc)
`endif
  );
  serial_modulo_detector #(.DIVISOR(3), .CNT_W(3)) c3 (.clk(clk), .rst(rst), .in_valid(in_valid), .in(in_bit),
    .frame_start(frame_start), .lsb_first(lsb_first), .out(c3_out), .out_valid(c3_ov),
    .residue(c3_res), .bit_count(c3_cnt)
`ifdef SERIAL_MOD_MATCH_CNT_EN
    , .match_count(c3_mc)
`endif
  );

  task automatic step(input logic fs, input logic iv, input logic b, input logic lsb);
    frame_start = fs; in_valid = iv; in_bit = b; lsb_first = lsb;
    @(posedge clk); #1;
    frame_start = 0; in_valid = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    tests += 4;
    if (d3_res !== 2'd0) begin fails++; $display("FAIL reset_residue got %0d want 0", d3_res); end
    if (d3_out !== 1'b1) begin fails++; $display("FAIL reset_out got %b want 1", d3_out); end
    if (d3_ov !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", d3_ov); end
    if (d3_cnt !== 8'd0) begin fails++; $display("FAIL reset_bit_count got %0d want 0", d3_cnt); end
    rst = 0;
  endtask

  task automatic test_msb();
    int bits[3] = '{1, 1, 0};
    int er[3] = '{1, 0, 0};
    int eo[3] = '{0, 1, 1};
    step(1, 0, 0, 0);
    tests += 2;
    if (d3_ov !== 1'b0) begin fails++; $display("FAIL msb_start_valid got %b want 0", d3_ov); end
    if (d3_out !== 1'b1) begin fails++; $display("FAIL msb_start_out got %b want 1", d3_out); end
    for (int i = 0; i < 3; i++) begin
      q.push_back('{r: er[i], c: i + 1, o: eo[i][0], v: 1'b1});
      step(0, 1, bits[i][0], 0);
      e = q.pop_front();
      tests += 4;
      if (d3_res !== e.r[1:0]) begin fails++; $display("FAIL msb_residue[%0d] got %0d want %0d", i, d3_res, e.r); end
      if (d3_out !== e.o) begin fails++; $display("FAIL msb_out[%0d] got %b want %b", i, d3_out, e.o); end
      if (d3_ov !== e.v) begin fails++; $display("FAIL msb_valid[%0d] got %b want %b", i, d3_ov, e.v); end
      if (d3_cnt !== e.c[7:0]) begin fails++; $display("FAIL msb_count[%0d] got %0d want %0d", i, d3_cnt, e.c); end
    end
  endtask

  task automatic test_lsb();
    int bits[3] = '{0, 1, 1};
    int er[3] = '{0, 2, 0};
    int eo[3] = '{1, 0, 1};
    step(1, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      q.push_back('{r: er[i], c: i + 1, o: eo[i][0], v: 1'b1});
      step(0, 1, bits[i][0], 1);
      e = q.pop_front();
      tests += 3;
      if (d3_res !== e.r[1:0]) begin fails++; $display("FAIL lsb_residue[%0d] got %0d want %0d", i, d3_res, e.r); end
      if (d3_out !== e.o) begin fails++; $display("FAIL lsb_out[%0d] got %b want %b", i, d3_out, e.o); end
      if (d3_cnt !== e.c[7:0]) begin fails++; $display("FAIL lsb_count[%0d] got %0d want %0d", i, d3_cnt, e.c); end
    end
  endtask

  task automatic test_div5();
    int bits[4] = '{1, 0, 1, 0};
    int er[4] = '{1, 2, 0, 0};
    int eo[4] = '{0, 0, 1, 1};
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      q.push_back('{r: er[i], c: i + 1, o: eo[i][0], v: 1'b1});
      step(0, 1, bits[i][0], 0);
      e = q.pop_front();
      tests += 2;
      if (d5_res !== e.r[2:0]) begin fails++; $display("FAIL div5_residue[%0d] got %0d want %0d", i, d5_res, e.r); end
      if (d5_out !== e.o) begin fails++; $display("FAIL div5_out[%0d] got %b want %b", i, d5_out, e.o); end
    end
  endtask

  task automatic test_restart();
    step(1, 0, 0, 0);
    step(0, 1, 1, 0);
    step(0, 1, 0, 0);
    tests++;
    if (d3_res !== 2'd2) begin fails++; $display("FAIL restart_pre got %0d want 2", d3_res); end
    q.push_back('{r: 1, c: 1, o: 1'b0, v: 1'b1});
    step(1, 1, 1, 0);
    e = q.pop_front();
    tests += 3;
    if (d3_res !== e.r[1:0]) begin fails++; $display("FAIL restart_residue got %0d want %0d", d3_res, e.r); end
    if (d3_cnt !== e.c[7:0]) begin fails++; $display("FAIL restart_count got %0d want %0d", d3_cnt, e.c); end
    if (d3_out !== e.o) begin fails++; $display("FAIL restart_out got %b want %b", d3_out, e.o); end
    q.push_back('{r: 2, c: 2, o: 1'b0, v: 1'b1});
    q.push_back('{r: 2, c: 3, o: 1'b0, v: 1'b1});
    for (int i = 0; i < 2; i++) begin
      step(0, 1, i[0], 1);
      e = q.pop_front();
      tests += 2;
      if (d3_res !== e.r[1:0]) begin fails++; $display("FAIL order_latch_residue[%0d] got %0d want %0d", i, d3_res, e.r); end
      if (d3_cnt !== e.c[7:0]) begin fails++; $display("FAIL order_latch_count[%0d] got %0d want %0d", i, d3_cnt, e.c); end
    end
  endtask

  task automatic test_hold_and_async_reset();
    for (int i = 0; i < 5; i++) begin
      q.push_back('{r: 2, c: 3, o: 1'b0, v: 1'b1});
      step(0, 0, i[0], 0);
      e = q.pop_front();
      tests += 2;
      if (d3_res !== e.r[1:0]) begin fails++; $display("FAIL hold_residue[%0d] got %0d want %0d", i, d3_res, e.r); end
      if (d3_cnt !== e.c[7:0]) begin fails++; $display("FAIL hold_count[%0d] got %0d want %0d", i, d3_cnt, e.c); end
    end
    #2 rst = 1;
    #1;
    tests += 4;
    if (d3_res !== 2'd0) begin fails++; $display("FAIL async_rst_residue got %0d want 0", d3_res); end
    if (d3_out !== 1'b1) begin fails++; $display("FAIL async_rst_out got %b want 1", d3_out); end
    if (d3_ov !== 1'b0) begin fails++; $display("FAIL async_rst_valid got %b want 0", d3_ov); end
    if (d3_cnt !== 8'd0) begin fails++; $display("FAIL async_rst_count got %0d want 0", d3_cnt); end
    #1 rst = 0;
  endtask

  task automatic test_saturate();
    int mr = 0;
    logic b;
    step(1, 0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      b = 1'($urandom_range(0, 1));
      mr = (2 * mr + int'(b)) % 3;
      q.push_back('{r: mr, c: (i > 7) ? 7 : i, o: mr == 0, v: 1'b1});
      step(0, 1, b, 0);
      e = q.pop_front();
      tests += 3;
      if (c3_res !== e.r[1:0]) begin fails++; $display("FAIL sat_residue[%0d] got %0d want %0d", i, c3_res, e.r); end
      if (c3_cnt !== e.c[2:0]) begin fails++; $display("FAIL sat_count[%0d] got %0d want %0d", i, c3_cnt, e.c); end
      if (c3_out !== e.o) begin fails++; $display("FAIL sat_out[%0d] got %b want %b", i, c3_out, e.o); end
    end
  endtask

`ifdef SERIAL_MOD_MATCH_CNT_EN
  task automatic test_match_count();
    int bits[4] = '{1, 1, 0, 0};
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, bits[i][0], 0);
    tests++;
    if (d3_mc !== 8'd3) begin fails++; $display("FAIL match_count got %0d want 3", d3_mc); end
    step(1, 1, 0, 0);
    tests++;
    if (d3_mc !== 8'd1) begin fails++; $display("FAIL match_count_restart got %0d want 1", d3_mc); end
  endtask
`endif

  task automatic test_back_to_back();
    int mr = 0, mw = 1, mc = 0;
    bit mv = 0, mord = 0;
    logic fs, iv, b, lsb;
    for (int i = 0; i < 60; i++) begin
      fs = (i == 0) || ($urandom_range(0, 9) == 0);
      iv = $urandom_range(0, 3) != 0;
      b = 1'($urandom_range(0, 1));
      lsb = 1'($urandom_range(0, 1));
      if (fs) begin mord = lsb; mr = 0; mw = 1; mc = 0; mv = 0; end
      if (iv) begin
        if (mord) begin mr = (mr + int'(b) * mw) % 5; mw = (mw * 2) % 5; end
        else mr = (mr * 2 + int'(b)) % 5;
        mc++;
        mv = 1;
      end
      q.push_back('{r: mr, c: mc, o: mr == 0, v: mv});
      step(fs, iv, b, lsb);
      e = q.pop_front();
      tests += 4;
      if (d5_res !== e.r[2:0]) begin fails++; $display("FAIL b2b_residue[%0d] got %0d want %0d", i, d5_res, e.r); end
      if (d5_out !== e.o) begin fails++; $display("FAIL b2b_out[%0d] got %b want %b", i, d5_out, e.o); end
      if (d5_ov !== e.v) begin fails++; $display("FAIL b2b_valid[%0d] got %b want %b", i, d5_ov, e.v); end
      if (d5_cnt !== e.c[7:0]) begin fails++; $display("FAIL b2b_count[%0d] got %0d want %0d", i, d5_cnt, e.c); end
    end
  endtask

  initial begin
    test_reset();
    test_msb();
    test_lsb();
    test_div5();
    test_restart();
    test_hold_and_async_reset();
    test_saturate();
`ifdef SERIAL_MOD_MATCH_CNT_EN
    test_match_count();
`endif
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
